psola_scheduler: RTL

PSOLA_SCHEDULER -- requirements
Module: psola_scheduler

---
 rtl/psola_scheduler_if.sv | 46 ++++
 rtl/psola_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/psola_scheduler_if.sv
// Signal bundle between the PSOLA scheduler and its surroundings: sample
// stream, pitch detector, frame buffer, PSOLA engine and output window memory.
interface psola_scheduler_if #(
  parameter int WINDOW_SIZE = 2048
);
  localparam int AW = $clog2(WINDOW_SIZE);

  logic                 sample_valid_in;
  logic signed [31:0]   sample_in;
  logic                 period_valid_in;
  logic        [11:0]   period_in;
  logic                 wr_en_out;
  logic                 wr_bank_out;
  logic        [AW-1:0] wr_addr_out;
  logic signed [31:0]   wr_data_out;
  logic                 psola_start_out;
  logic                 psola_bank_out;
  logic        [11:0]   psola_period_out;
  logic                 psola_done_in;
  logic        [11:0]   psola_len_in;
  logic        [11:0]   rd_addr_out;
  logic signed [31:0]   rd_data_in;
  logic signed [31:0]   sample_out;
  logic                 sample_valid_out;
  logic                 overrun_out;
  logic                 timeout_out;
  logic                 busy_out;

  modport master (
    input  sample_valid_in, sample_in, period_valid_in, period_in,
           psola_done_in, psola_len_in, rd_data_in,
    output wr_en_out, wr_bank_out, wr_addr_out, wr_data_out,
           psola_start_out, psola_bank_out, psola_period_out,
           rd_addr_out, sample_out, sample_valid_out,
           overrun_out, timeout_out, busy_out
  );

  modport slave (
    output sample_valid_in, sample_in, period_valid_in, period_in,
           psola_done_in, psola_len_in, rd_data_in,
    input  wr_en_out, wr_bank_out, wr_addr_out, wr_data_out,
           psola_start_out, psola_bank_out, psola_period_out,
           rd_addr_out, sample_out, sample_valid_out,
           overrun_out, timeout_out, busy_out
  );
endinterface

// File: rtl/psola_scheduler.sv
// Ping-pong frame capture plus PSOLA job scheduling: launches the engine on each
// completed frame, waits for it, then plays the output window one sample per tick.
module psola_scheduler #(
  parameter int WINDOW_SIZE    = 2048,
  parameter int MIN_PERIOD     = 20,
  parameter int MAX_PERIOD     = 1000,
  parameter int DEFAULT_PERIOD = 200,
  parameter int TIMEOUT        = 65535
) (
  input  logic               clk_in,
  input  logic               rst_in,
  psola_scheduler_if.master  bus
);
  localparam int DATA_W  = 32;
  localparam int AW      = $clog2(WINDOW_SIZE);
  localparam int LEN_CAP = 2 * WINDOW_SIZE;
  localparam int TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, PLAY} state_t;

  function automatic logic [11:0] clamp_len(input logic [11:0] len);
    if (int'(len) > LEN_CAP) return 12'(LEN_CAP);
    return len;
  endfunction

  function automatic logic period_ok(input logic [11:0] p);
    return (int'(p) >= MIN_PERIOD) && (int'(p) <= MAX_PERIOD);
  endfunction

  // capture / frame bookkeeping
  logic [AW-1:0]             fill_ptr;
  logic                      fill_bank;
  logic                      pending;
  logic                      overrun;
  logic [11:0]               period_reg;
  logic                      wr_vld_p0;
  logic                      wr_bank_p0;
  logic [AW-1:0]             wr_addr_p0;
  logic signed [DATA_W-1:0]  wr_data_p0;

  // scheduler
  state_t                    state;
  logic                      start_p0;
  logic                      bank_p0;
  logic [11:0]               period_p0;
  logic                      busy;
  logic                      timeout;
  logic [TW-1:0]             tcount;
  logic [11:0]               len_reg;
  logic [11:0]               play_ptr;
  logic                      out_vld_p0;
  logic                      out_play_p0;

  logic frame_wrap;
  logic play_tick;
  logic last_tick;
  logic consume;
  logic done_bank;

  assign frame_wrap = bus.sample_valid_in && (&fill_ptr);
  assign play_tick  = (state == PLAY) && bus.sample_valid_in;
  assign last_tick  = (play_ptr == len_reg - 12'd1);
  assign consume    = pending && ((state == IDLE) || (play_tick && last_tick));
  // A frame finishing on the same edge it is consumed is the newest one, so take it.
  assign done_bank  = frame_wrap ? fill_bank : ~fill_bank;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fill_ptr   <= '0;
      fill_bank  <= 1'b0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      period_reg <= 12'(DEFAULT_PERIOD);
      wr_vld_p0  <= 1'b0;
      wr_bank_p0 <= 1'b0;
      wr_addr_p0 <= '0;
      wr_data_p0 <= '0;
    end else begin
      // stage p0: frame-buffer write
      wr_vld_p0 <= bus.sample_valid_in;
      if (bus.sample_valid_in) begin
        wr_addr_p0 <= fill_ptr;
        wr_bank_p0 <= fill_bank;
        wr_data_p0 <= bus.sample_in;
        fill_ptr   <= fill_ptr + 1'b1;
        if (frame_wrap) fill_bank <= ~fill_bank;
      end
      if (frame_wrap && pending) overrun <= 1'b1;
      if (frame_wrap && !consume) pending <= 1'b1;
      else if (consume)           pending <= 1'b0;
      if (bus.period_valid_in && period_ok(bus.period_in)) period_reg <= bus.period_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      start_p0    <= 1'b0;
      bank_p0     <= 1'b0;
      period_p0   <= '0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
      tcount      <= '0;
      len_reg     <= '0;
      play_ptr    <= '0;
      out_vld_p0  <= 1'b0;
      out_play_p0 <= 1'b0;
    end else begin
      start_p0    <= 1'b0;
      // stage p0: output strobe; read data arrives with this strobe
      out_vld_p0  <= bus.sample_valid_in;
      out_play_p0 <= play_tick;
      case (state)
        IDLE: ;
        START: begin
          state  <= WAIT_DONE;
          tcount <= '0;
        end
        WAIT_DONE: begin
          if (bus.psola_done_in) begin
            len_reg  <= clamp_len(bus.psola_len_in);
            play_ptr <= '0;
            if (bus.psola_len_in == 12'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= PLAY;
            end
          end else if (tcount == TW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        PLAY: begin
          if (play_tick) begin
            if (last_tick) begin
              play_ptr <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              play_ptr <= play_ptr + 12'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Launch from IDLE or straight out of PLAY when another frame is waiting.
      if (consume) begin
        state     <= START;
        start_p0  <= 1'b1;
        bank_p0   <= done_bank;
        period_p0 <= period_reg;
        busy      <= 1'b1;
      end
    end
  end

  assign bus.wr_en_out        = wr_vld_p0;
  assign bus.wr_bank_out      = wr_bank_p0;
  assign bus.wr_addr_out      = wr_addr_p0;
  assign bus.wr_data_out      = wr_data_p0;
  assign bus.psola_start_out  = start_p0;
  assign bus.psola_bank_out   = bank_p0;
  assign bus.psola_period_out = period_p0;
  assign bus.rd_addr_out      = play_ptr;
  assign bus.sample_out       = out_play_p0 ? bus.rd_data_in : '0;
  assign bus.sample_valid_out = out_vld_p0;
  assign bus.overrun_out      = overrun;
  assign bus.timeout_out      = timeout;
  assign bus.busy_out         = busy;
endmodule
